cp0_exc_seq: RTL and testbench
==============================

# cp0_exc_seq

Exception/ERET sequencer sitting directly upstream of the CP0 register file. It accepts exception, interrupt and ERET requests from the pipeline and serialises the resulting EPC/Cause/BadVAddr/Status updates onto the register file's single write-data bus, one register per cycle. When the sequence completes it issues a one-cycle PC redirect, to the exception vector or to EPC. The pipeline is stalled while the sequence runs.

## Interface
- EXC_VECTOR, 32'h8000_0180, exception entry address
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exc_req  in  1  synchronous exception request from the pipeline
- exc_code  in  5  ExcCode for exc_req
- exc_pc  in  32  PC of the faulting instruction
- exc_bd  in  1  faulting instruction is in a branch delay slot
- exc_has_badv  in  1  exception carries a bad virtual address
- exc_badv  in  32  bad virtual address
- eret_req  in  1  ERET executing
- int_pc  in  32  PC of the next instruction to commit (interrupt EPC)
- hw_int  in  6  hardware interrupt lines, level-sensitive
- cp0_status, cp0_cause, cp0_epc  in  32 each  current register values
- req_ack  out  1  request accepted this cycle (combinational)
- busy  out  1  stall pipeline; no MTC0 is issued while high
- cp0_wdata  out  32  write data to the register file
- we_epc, we_cause, we_badVAddr, we_status  out  1 each  register write strobes, at most one high
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target

## Operation
- Field layout: Status IE=bit0, EXL=bit1, IM=bits15:8. Cause BD=bit31, IP=bits15:8 (hw_int on IP7..IP2), ExcCode=bits6:2.
- int_take = IE & ~EXL & |(hw_int & IM[15:10]).
- Priority in IDLE: exc_req > int_take > eret_req. ERET is accepted only when EXL=1. An ERET with EXL=0 is acked and ignored: no writes, no redirect.
- On accept, the block latches the code (0 for interrupt), BD, EPC value, badv, has_badv, the sampled hw_int, the Status snapshot, the Cause snapshot and cp0_epc.
- EPC value: exc_bd ? exc_pc−4 : exc_pc (mod 2^32). For an interrupt it is int_pc, with BD=0.
- FSM states: IDLE, W_EPC, W_CAUSE, W_BADV, W_STATUS, REDIR.
- Exception/interrupt path: W_EPC → W_CAUSE → W_BADV → W_STATUS → REDIR → IDLE.
  - W_EPC is skipped when the snapshot EXL=1 (nested exception). In that case Cause.BD is also left unchanged.
  - W_BADV is skipped when has_badv=0.
- Written values:
  - Cause = snapshot with BD, IP7..IP2 and ExcCode replaced.
  - Status = snapshot | 32'h2.
  - redirect_pc = EXC_VECTOR.
- ERET path: W_STATUS (snapshot & ~32'h2) → REDIR, with redirect_pc = latched cp0_epc.
- cp0_wdata holds the value for the current W_* state; it is 0 in IDLE and REDIR.

## Timing
- Reset: state IDLE. busy, all we_*, redirect_valid and req_ack are 0. cp0_wdata and redirect_pc are 0.
- Accept at cycle T (IDLE, req_ack=1). busy is registered and goes high from T+1 through REDIR inclusive.
- Each W_* state lasts exactly one cycle. Its strobe is high during that cycle and the register file captures the value at the closing edge.
- Latency, accept to redirect_valid:
  - full exception: T+5
  - no badv: T+4
  - nested without badv: T+3
  - ERET: T+2
- Requests arriving while busy are not acked. The pipeline holds them.
- hw_int changes after accept do not affect the sequence in flight.
- Reset asserted mid-sequence: return to IDLE immediately, all outputs deassert. Writes already strobed remain.

## Structure
- Shared package: Status/Cause bit positions, ExcCode constants (INT=0, ADEL=4, SYS=8, ...) and the FSM state encoding.
- No sub-module: a single FSM plus a capture register bank.

## Test plan
- exc_req, code 4, exc_pc=0x400, bd=0, badv=0x1233, Status=0x0000_FF01 → EPC=0x400, Cause[6:2]=4, BadVAddr=0x1233, Status=0xFF03; redirect to 0x8000_0180 at T+5.
- exc_req, bd=1, exc_pc=0x1000, no badv → EPC=0xFFC, Cause bit31=1, no we_badVAddr; redirect at T+4.
- Status=0x0000_0401, hw_int=6'b000001, int_pc=0x2000 → interrupt taken, ExcCode 0, IP2 set, EPC=0x2000. Repeat with IE=0 → no ack.
- Status EXL=1, exc_req code 8 → we_epc never asserted, Cause BD unchanged, redirect at T+3.
- EXL=1, cp0_epc=0x2000, eret_req → Status EXL cleared at T+1, redirect_pc=0x2000 at T+2. Repeat with EXL=0 → acked, no writes, no redirect.
- rst_n low during W_CAUSE → all outputs 0 the same cycle. A simultaneous exc_req and eret_req after release → exception path chosen.

Source files
------------

// File: rtl/cp0_exc_seq_pkg.sv
// rtl/cp0_exc_seq_pkg.sv - shared field positions, ExcCodes and FSM encoding for cp0_exc_seq
package cp0_exc_seq_pkg;

  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  // Status fields
  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 1;
  localparam int ST_IM_LO   = 8;
  localparam int ST_IM_HI   = 15;
  // IM bits that mask the six hardware interrupt lines (IM7..IM2)
  localparam int ST_IM_HWLO = 10;

  // Cause fields
  localparam int CA_BD      = 31;
  localparam int CA_IP_LO   = 8;
  localparam int CA_IP_HI   = 15;
  localparam int CA_IP_HWLO = 10;
  localparam int CA_EXC_LO  = 2;
  localparam int CA_EXC_HI  = 6;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_IBE  = 5'd6;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_CPU  = 5'd11;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_TR   = 5'd13;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_W_EPC    = 3'd1,
    S_W_CAUSE  = 3'd2,
    S_W_BADV   = 3'd3,
    S_W_STATUS = 3'd4,
    S_REDIR    = 3'd5
  } state_t;

  // New Cause value: ExcCode and IP7..IP2 always replaced, BD only when not nested
  function automatic logic [31:0] merge_cause(input logic [31:0] snap,
                                              input logic        keep_bd,
                                              input logic        bd,
                                              input logic [5:0]  hw,
                                              input logic [4:0]  code);
    logic [31:0] c;
    c = snap;
    c[CA_EXC_HI:CA_EXC_LO] = code;
    c[CA_IP_HI:CA_IP_HWLO] = hw;
    if (!keep_bd) c[CA_BD] = bd;
    return c;
  endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// rtl/cp0_exc_seq.sv - exception/interrupt/ERET sequencer serialising CP0 register updates
module cp0_exc_seq
  import cp0_exc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_has_badv,
  input  logic [31:0] exc_badv,
  input  logic        eret_req,
  input  logic [31:0] int_pc,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        req_ack,
  output logic        busy,
  output logic [31:0] cp0_wdata,
  output logic        we_epc,
  output logic        we_cause,
  output logic        we_badVAddr,
  output logic        we_status,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  state_t      state, state_d;

  // Capture bank: everything the sequence needs, frozen at accept
  logic [4:0]  cap_code,     cap_code_d;
  logic        cap_bd,       cap_bd_d;
  logic [31:0] cap_epc_val,  cap_epc_val_d;
  logic [31:0] cap_badv,     cap_badv_d;
  logic        cap_has_badv, cap_has_badv_d;
  logic [5:0]  cap_hw,       cap_hw_d;
  logic [31:0] cap_status,   cap_status_d;
  logic [31:0] cap_cause,    cap_cause_d;
  logic [31:0] cap_epc_reg,  cap_epc_reg_d;
  logic        cap_eret,     cap_eret_d;

  logic        int_take;
  logic        any_req;
  logic        idle;

  logic [31:0] wdata_d;
  logic [31:0] redirect_pc_d;

  // Request arbitration; ack is combinational and suppressed while in reset
  always_comb begin
    int_take = cp0_status[ST_IE] & ~cp0_status[ST_EXL] &
               (|(hw_int & cp0_status[ST_IM_HI:ST_IM_HWLO]));
    any_req  = exc_req | int_take | eret_req;
    idle     = (state == S_IDLE);
    req_ack  = rst_n & idle & any_req;
  end

  // Next state and next capture-bank contents
  always_comb begin
    state_d        = state;
    cap_code_d     = cap_code;
    cap_bd_d       = cap_bd;
    cap_epc_val_d  = cap_epc_val;
    cap_badv_d     = cap_badv;
    cap_has_badv_d = cap_has_badv;
    cap_hw_d       = cap_hw;
    cap_status_d   = cap_status;
    cap_cause_d    = cap_cause;
    cap_epc_reg_d  = cap_epc_reg;
    cap_eret_d     = cap_eret;

    case (state)
      S_IDLE: begin
        if (any_req) begin
          cap_hw_d      = hw_int;
          cap_status_d  = cp0_status;
          cap_cause_d   = cp0_cause;
          cap_epc_reg_d = cp0_epc;
        end
        if (exc_req) begin
          cap_code_d     = exc_code;
          cap_bd_d       = exc_bd;
          cap_epc_val_d  = exc_bd ? (exc_pc - 32'd4) : exc_pc;
          cap_badv_d     = exc_badv;
          cap_has_badv_d = exc_has_badv;
          cap_eret_d     = 1'b0;
          // Nested exception leaves EPC alone
          state_d        = cp0_status[ST_EXL] ? S_W_CAUSE : S_W_EPC;
        end else if (int_take) begin
          cap_code_d     = EXC_INT;
          cap_bd_d       = 1'b0;
          cap_epc_val_d  = int_pc;
          cap_badv_d     = 32'd0;
          cap_has_badv_d = 1'b0;
          cap_eret_d     = 1'b0;
          state_d        = S_W_EPC;
        end else if (eret_req) begin
          cap_has_badv_d = 1'b0;
          cap_eret_d     = 1'b1;
          // ERET outside exception level is acked but has no effect
          state_d        = cp0_status[ST_EXL] ? S_W_STATUS : S_IDLE;
        end
      end
      S_W_EPC:    state_d = S_W_CAUSE;
      S_W_CAUSE:  state_d = cap_has_badv ? S_W_BADV : S_W_STATUS;
      S_W_BADV:   state_d = S_W_STATUS;
      S_W_STATUS: state_d = S_REDIR;
      S_REDIR:    state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Values to present in the state being entered, so outputs can be registered
  always_comb begin
    wdata_d       = 32'd0;
    redirect_pc_d = 32'd0;
    case (state_d)
      S_W_EPC:    wdata_d = cap_epc_val_d;
      S_W_CAUSE:  wdata_d = merge_cause(cap_cause_d, cap_status_d[ST_EXL], cap_bd_d,
                                        cap_hw_d, cap_code_d);
      S_W_BADV:   wdata_d = cap_badv_d;
      S_W_STATUS: wdata_d = cap_eret_d ? (cap_status_d & ~32'h2) : (cap_status_d | 32'h2);
      S_REDIR:    redirect_pc_d = cap_eret_d ? cap_epc_reg_d : EXC_VECTOR;
      default: begin
        wdata_d       = 32'd0;
        redirect_pc_d = 32'd0;
      end
    endcase
  end

  // Sequencer FSM with registered strobes, data and redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      we_epc         <= 1'b0;
      we_cause       <= 1'b0;
      we_badVAddr    <= 1'b0;
      we_status      <= 1'b0;
      redirect_valid <= 1'b0;
      cp0_wdata      <= 32'd0;
      redirect_pc    <= 32'd0;
    end else begin
      state          <= state_d;
      busy           <= (state_d != S_IDLE);
      we_epc         <= (state_d == S_W_EPC);
      we_cause       <= (state_d == S_W_CAUSE);
      we_badVAddr    <= (state_d == S_W_BADV);
      we_status      <= (state_d == S_W_STATUS);
      redirect_valid <= (state_d == S_REDIR);
      cp0_wdata      <= wdata_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

  // Capture register bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_code     <= 5'd0;
      cap_bd       <= 1'b0;
      cap_epc_val  <= 32'd0;
      cap_badv     <= 32'd0;
      cap_has_badv <= 1'b0;
      cap_hw       <= 6'd0;
      cap_status   <= 32'd0;
      cap_cause    <= 32'd0;
      cap_epc_reg  <= 32'd0;
      cap_eret     <= 1'b0;
    end else begin
      cap_code     <= cap_code_d;
      cap_bd       <= cap_bd_d;
      cap_epc_val  <= cap_epc_val_d;
      cap_badv     <= cap_badv_d;
      cap_has_badv <= cap_has_badv_d;
      cap_hw       <= cap_hw_d;
      cap_status   <= cap_status_d;
      cap_cause    <= cap_cause_d;
      cap_epc_reg  <= cap_epc_reg_d;
      cap_eret     <= cap_eret_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_seq.sv
// tb/tb_cp0_exc_seq.sv - scoreboard bench for cp0_exc_seq with a rule-level reference model
module tb_cp0_exc_seq;

  localparam logic [31:0] VEC = 32'h8000_0180;
  localparam int K_EPC = 0, K_CAUSE = 1, K_BADV = 2, K_STATUS = 3, K_REDIR = 4;

  logic        clk, rst_n;
  logic        exc_req, exc_bd, exc_has_badv, eret_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc, exc_badv, int_pc, cp0_status, cp0_cause, cp0_epc;
  logic [5:0]  hw_int;
  logic        req_ack, busy, we_epc, we_cause, we_badVAddr, we_status, redirect_valid;
  logic [31:0] cp0_wdata, redirect_pc;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] data;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  busy_start = 1;
  int  busy_end = 0;
  int  n_checks = 0;
  int  n_err = 0;

  cp0_exc_seq dut (
    .clk(clk), .rst_n(rst_n),
    .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
    .exc_has_badv(exc_has_badv), .exc_badv(exc_badv), .eret_req(eret_req),
    .int_pc(int_pc), .hw_int(hw_int),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .req_ack(req_ack), .busy(busy), .cp0_wdata(cp0_wdata),
    .we_epc(we_epc), .we_cause(we_cause), .we_badVAddr(we_badVAddr), .we_status(we_status),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input int k, input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.data = d;
    q.push_back(e);
  endtask

  // Drive one cycle of pipeline inputs, check the ack and record what must follow
  task automatic step(input logic e, input logic [4:0] code, input logic [31:0] pc,
                      input logic bd, input logic hb, input logic [31:0] bv,
                      input logic er, input logic [31:0] ipc, input logic [5:0] hw,
                      input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    bit          idle, itake, ack_exp, nested, bdv, hbv;
    int          t, k;
    logic [4:0]  cd;
    logic [31:0] epcv, cause_new;
    @(negedge clk);
    exc_req = e; exc_code = code; exc_pc = pc; exc_bd = bd; exc_has_badv = hb;
    exc_badv = bv; eret_req = er; int_pc = ipc; hw_int = hw;
    cp0_status = st; cp0_cause = ca; cp0_epc = ep;
    #1;
    idle    = (cyc > busy_end);
    itake   = st[0] && !st[1] && ((hw & st[15:10]) != 6'd0);
    ack_exp = idle && (e || itake || er);
    chk("req_ack", {31'd0, req_ack}, {31'd0, ack_exp});
    if (ack_exp) begin
      t = cyc;
      k = t + 1;
      if (e || itake) begin
        if (e) begin
          cd = code; epcv = bd ? pc - 32'd4 : pc; bdv = bd; hbv = hb;
        end else begin
          cd = 5'd0; epcv = ipc; bdv = 1'b0; hbv = 1'b0;
        end
        nested = st[1];
        if (!nested) begin
          push_ev(k, K_EPC, epcv); k++;
        end
        cause_new = ca;
        cause_new[6:2] = cd;
        cause_new[15:10] = hw;
        if (!nested) cause_new[31] = bdv;
        push_ev(k, K_CAUSE, cause_new); k++;
        if (hbv) begin
          push_ev(k, K_BADV, bv); k++;
        end
        push_ev(k, K_STATUS, st | 32'h2); k++;
        push_ev(k, K_REDIR, VEC);
        busy_start = t + 1;
        busy_end   = k;
      end else if (st[1]) begin
        push_ev(k, K_STATUS, st & ~32'h2); k++;
        push_ev(k, K_REDIR, ep);
        busy_start = t + 1;
        busy_end   = k;
      end
    end
  endtask

  task automatic step_idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 6'd0,
         $urandom, $urandom, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && cyc <= busy_end; i++) step_idle();
  endtask

  // Monitor: compare every strobe/redirect against the head of the scoreboard
  initial begin : monitor
    int          nact, kind;
    logic [31:0] data;
    ev_t         ev;
    bit          busy_exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        busy_exp = (cyc >= busy_start) && (cyc <= busy_end);
        chk("busy", {31'd0, busy}, {31'd0, busy_exp});
        nact = int'(we_epc) + int'(we_cause) + int'(we_badVAddr) + int'(we_status)
             + int'(redirect_valid);
        if (nact > 1) chk("strobe_onehot", nact, 1);
        kind = we_epc ? K_EPC : we_cause ? K_CAUSE : we_badVAddr ? K_BADV :
               we_status ? K_STATUS : K_REDIR;
        data = redirect_valid ? redirect_pc : cp0_wdata;
        while (q.size() > 0 && q[0].cyc < cyc) begin
          ev = q.pop_front();
          n_checks++; n_err++;
          $display("FAIL missed_event kind %0d due cycle %0d data %h, not seen (now cycle %0d)",
                   ev.kind, ev.cyc, ev.data, cyc);
        end
        if (nact >= 1) begin
          if (q.size() == 0) begin
            n_checks++; n_err++;
            $display("FAIL unexpected_event kind %0d data %h at cycle %0d, expected none",
                     kind, data, cyc);
          end else begin
            ev = q.pop_front();
            chk("event_cycle", cyc, ev.cyc);
            chk("event_kind", kind, ev.kind);
            chk("event_data", data, ev.data);
          end
        end else begin
          chk("wdata_idle", cp0_wdata, 32'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    exc_req = 0; exc_code = 0; exc_pc = 0; exc_bd = 0; exc_has_badv = 0; exc_badv = 0;
    eret_req = 0; int_pc = 0; hw_int = 0; cp0_status = 0; cp0_cause = 0; cp0_epc = 0;
    repeat (3) @(negedge clk);
    exc_req = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ack", {31'd0, req_ack}, 32'd0);
    chk("rst_strobes", {27'd0, we_epc, we_cause, we_badVAddr, we_status, redirect_valid}, 32'd0);
    chk("rst_wdata", cp0_wdata, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    exc_req = 1'b0;
    #1 rst_n = 1'b1;

    // Full exception with badv
    step(1'b1, 5'd4, 32'h400, 1'b0, 1'b1, 32'h1233, 1'b0, 32'h0, 6'd0,
         32'h0000_FF01, 32'h0, 32'h0);
    drain();
    // Delay-slot exception without badv
    step(1'b1, 5'd5, 32'h1000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0,
         32'h0000_FF01, 32'h0, 32'h0);
    drain();
    // Interrupt taken, then masked by IE=0
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2000, 6'b000001,
         32'h0000_0401, 32'h0, 32'h0);
    drain();
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h2000, 6'b000001,
         32'h0000_0400, 32'h0, 32'h0);
    drain();
    // Nested syscall keeps EPC and Cause.BD
    step(1'b1, 5'd8, 32'h3000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 6'd0,
         32'h0000_0003, 32'h8000_0000, 32'h0);
    drain();
    // ERET with EXL set, then with EXL clear
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 6'd0,
         32'h0000_FF03, 32'h0, 32'h2000);
    drain();
    step(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 6'd0,
         32'h0000_FF01, 32'h0, 32'h2000);
    drain();

    // Reset while in W_CAUSE
    step(1'b1, 5'd4, 32'h500, 1'b0, 1'b1, 32'hABCD, 1'b0, 32'h0, 6'd0,
         32'h0000_0000, 32'h0, 32'h0);
    step_idle();
    @(negedge clk);
    exc_req = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_req_ack", {31'd0, req_ack}, 32'd0);
    chk("midrst_strobes", {27'd0, we_epc, we_cause, we_badVAddr, we_status, redirect_valid}, 32'd0);
    chk("midrst_wdata", cp0_wdata, 32'd0);
    chk("midrst_redirect_pc", redirect_pc, 32'd0);
    exc_req = 1'b0;
    q.delete();
    busy_end = cyc;
    @(negedge clk);
    #2 rst_n = 1'b1;
    // Simultaneous exception and ERET: exception wins
    step(1'b1, 5'd12, 32'h600, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 6'd0,
         32'h0000_0002, 32'h0, 32'h7777);
    drain();

    // Randomized traffic, inputs change every cycle including mid-sequence
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 3) == 0, 5'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom,
           ($urandom % 3) == 0, $urandom, ($urandom % 2) ? 6'($urandom) : 6'd0,
           $urandom, $urandom, $urandom);
    end
    drain();
    repeat (3) step_idle();
    chk("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
